// File: rtl/lru_pkg.sv
// Shared types and helper functions for the LRU replacement tracker.
// The helpers take fixed maximum-width vectors so one definition works for
// any way count. The caller zero-extends its ages/valid bits and passes the
// real way count.
package lru_pkg;

    localparam int MAX_WAYS  = 64;
    localparam int MAX_WAY_W = 6;

    typedef logic [MAX_WAY_W-1:0] way_idx_t;

    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_ACCESS = 2'd1,
        OP_INVAL  = 2'd2
    } lru_op_e;

    typedef struct packed {
        way_idx_t way;
        logic     found;
    } free_way_t;

    // Returns the way whose age equals ways-1 (the least recently used one).
    // Because the ages form a permutation, exactly one way matches.
    function automatic way_idx_t find_lru(
        input logic [MAX_WAYS*MAX_WAY_W-1:0] ages,
        input int                            ways
    );
        way_idx_t res;
        res = '0;
        for (int w = 0; w < MAX_WAYS; w++) begin
            if (w < ways && ages[w*MAX_WAY_W +: MAX_WAY_W] == way_idx_t'(ways - 1)) begin
                res = way_idx_t'(w);
            end
        end
        return res;
    endfunction

    // Returns the lowest-index invalid way and whether one exists. The loop
    // runs downward so the lowest match is the last one written.
    function automatic free_way_t first_invalid(
        input logic [MAX_WAYS-1:0] valid,
        input int                  ways
    );
        free_way_t res;
        res.way   = '0;
        res.found = 1'b0;
        for (int w = MAX_WAYS - 1; w >= 0; w--) begin
            if (w < ways && !valid[w]) begin
                res.way   = way_idx_t'(w);
                res.found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lru_age_update.sv
// Next-state computation for the ages and valid bits of one set.
// Access promotes the way to MRU and ages every younger way by one.
// Invalidate demotes the way to LRU and rejuvenates every older way by one.
// Either way, the ages remain a permutation of 0..WAYS-1.
module lru_age_update
    import lru_pkg::*;
#(
    parameter  int WAYS  = 8,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][WAY_W-1:0] old_age,
    input  logic [WAYS-1:0]            old_valid,
    input  lru_op_e                    op,
    input  logic [WAY_W-1:0]           way,
    output logic [WAYS-1:0][WAY_W-1:0] new_age,
    output logic [WAYS-1:0]            new_valid
);

    logic [WAY_W-1:0] sel_age;

    assign sel_age = old_age[way];

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic             hit;
        logic [WAY_W-1:0] acc_age;
        logic [WAY_W-1:0] inv_age;

        assign hit     = (way == WAY_W'(gi));
        assign acc_age = hit ? '0
                       : (old_age[gi] < sel_age) ? old_age[gi] + 1'b1
                       : old_age[gi];
        assign inv_age = hit ? WAY_W'(WAYS - 1)
                       : (old_age[gi] > sel_age) ? old_age[gi] - 1'b1
                       : old_age[gi];

        assign new_age[gi]   = (op == OP_ACCESS) ? acc_age
                             : (op == OP_INVAL)  ? inv_age
                             : old_age[gi];
        assign new_valid[gi] = (hit && op == OP_ACCESS) ? 1'b1
                             : (hit && op == OP_INVAL)  ? 1'b0
                             : old_valid[gi];
    end

endmodule

// File: rtl/lru_set_array.sv
// True-LRU replacement tracker for all sets of a set-associative cache.
// It keeps one access write port and one invalidate write port.
// The victim query is combinational from the registered state, with no bypass
// of same-cycle updates.
module lru_set_array
    import lru_pkg::*;
#(
    parameter  int WAYS  = 8,
    parameter  int SETS  = 16,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             access_valid,
    input  logic [SET_W-1:0] access_set,
    input  logic [WAY_W-1:0] access_way,
    input  logic             inval_valid,
    input  logic [SET_W-1:0] inval_set,
    input  logic [WAY_W-1:0] inval_way,
    input  logic [SET_W-1:0] query_set,
    output logic [WAY_W-1:0] evict_way,
    output logic             evict_is_invalid,
    output logic             set_full
);

    typedef logic [WAY_W-1:0] age_t;

    if (WAYS > MAX_WAYS || WAYS < 2) begin : g_bad_ways
        $error("lru_set_array: WAYS out of supported range");
    end

    // Per-set state. Every set needs reset at once and has two write ports,
    // so the state is held in flops.
    age_t [WAYS-1:0] age_reg   [SETS];
    logic [WAYS-1:0] valid_reg [SETS];

    age_t [WAYS-1:0] acc_age_next;
    logic [WAYS-1:0] acc_valid_next;
    age_t [WAYS-1:0] inv_age_next;
    logic [WAYS-1:0] inv_valid_next;
    logic            inval_apply;
    lru_op_e         acc_op;
    lru_op_e         inv_op;

    // When both ports target the same set, the access wins. The controller
    // then retries the invalidate.
    assign inval_apply = inval_valid && !(access_valid && access_set == inval_set);
    assign acc_op      = access_valid ? OP_ACCESS : OP_NONE;
    assign inv_op      = inval_apply  ? OP_INVAL  : OP_NONE;

    lru_age_update #(.WAYS(WAYS)) u_access_update (
        .old_age   (age_reg[access_set]),
        .old_valid (valid_reg[access_set]),
        .op        (acc_op),
        .way       (access_way),
        .new_age   (acc_age_next),
        .new_valid (acc_valid_next)
    );

    lru_age_update #(.WAYS(WAYS)) u_inval_update (
        .old_age   (age_reg[inval_set]),
        .old_valid (valid_reg[inval_set]),
        .op        (inv_op),
        .way       (inval_way),
        .new_age   (inv_age_next),
        .new_valid (inv_valid_next)
    );

    // State update: reset restores identity ages and clears valid bits.
    // Otherwise the two ports write their own (distinct) sets.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_reg[s][w] <= age_t'(w);
                end
                valid_reg[s] <= '0;
            end
        end else begin
            if (access_valid) begin
                age_reg[access_set]   <= acc_age_next;
                valid_reg[access_set] <= acc_valid_next;
            end
            if (inval_apply) begin
                age_reg[inval_set]   <= inv_age_next;
                valid_reg[inval_set] <= inv_valid_next;
            end
        end
    end

    logic [MAX_WAYS*MAX_WAY_W-1:0] ages_ext;
    logic [MAX_WAYS-1:0]           valid_ext;
    free_way_t                     free_way;
    way_idx_t                      lru_way;

    // Victim selection: prefer the lowest invalid way, else the LRU way.
    always_comb begin
        ages_ext = '0;
        for (int w = 0; w < WAYS; w++) begin
            ages_ext[w*MAX_WAY_W +: MAX_WAY_W] = MAX_WAY_W'(age_reg[query_set][w]);
        end
        valid_ext = MAX_WAYS'(valid_reg[query_set]);
        free_way  = first_invalid(valid_ext, WAYS);
        lru_way   = find_lru(ages_ext, WAYS);
        if (free_way.found) begin
            evict_way        = WAY_W'(free_way.way);
            evict_is_invalid = 1'b1;
        end else begin
            evict_way        = WAY_W'(lru_way);
            evict_is_invalid = 1'b0;
        end
        set_full = &valid_reg[query_set];
    end

endmodule

// File: tb/tb_lru_set_array.sv
// Bench for lru_set_array. It runs directed scenarios on a 4-way and an 8-way
// instance. It also runs randomized traffic on the 8-way instance, checked
// against a recency-queue model (front = MRU, back = LRU).
module tb_lru_set_array;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a8_v = 1'b0, i8_v = 1'b0;
    logic [3:0] a8_s = '0, i8_s = '0, q8_s = '0;
    logic [2:0] a8_w = '0, i8_w = '0, e8_w;
    logic       e8_inv, f8;

    logic       a4_v = 1'b0, i4_v = 1'b0;
    logic [3:0] a4_s = '0, i4_s = '0, q4_s = '0;
    logic [1:0] a4_w = '0, i4_w = '0, e4_w;
    logic       e4_inv, f4;

    int checks = 0;
    int passed = 0;

    int order8 [16][$];
    bit mvalid8 [16][8];

    always #5 clk = ~clk;

    lru_set_array #(.WAYS(8), .SETS(16)) dut8 (
        .clk(clk), .rst(rst),
        .access_valid(a8_v), .access_set(a8_s), .access_way(a8_w),
        .inval_valid(i8_v), .inval_set(i8_s), .inval_way(i8_w),
        .query_set(q8_s), .evict_way(e8_w), .evict_is_invalid(e8_inv), .set_full(f8)
    );

    lru_set_array #(.WAYS(4), .SETS(16)) dut4 (
        .clk(clk), .rst(rst),
        .access_valid(a4_v), .access_set(a4_s), .access_way(a4_w),
        .inval_valid(i4_v), .inval_set(i4_s), .inval_way(i4_w),
        .query_set(q4_s), .evict_way(e4_w), .evict_is_invalid(e4_inv), .set_full(f4)
    );

    // ---------------- reference model (8-way) ----------------
    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            order8[s].delete();
            for (int w = 0; w < 8; w++) begin
                order8[s].push_back(w);
                mvalid8[s][w] = 1'b0;
            end
        end
    endtask

    function automatic int model_pos(int s, int w);
        for (int i = 0; i < order8[s].size(); i++) begin
            if (order8[s][i] == w) return i;
        end
        return -1;
    endfunction

    task automatic model_access(int s, int w);
        order8[s].delete(model_pos(s, w));
        order8[s].push_front(w);
        mvalid8[s][w] = 1'b1;
    endtask

    task automatic model_inval(int s, int w);
        order8[s].delete(model_pos(s, w));
        order8[s].push_back(w);
        mvalid8[s][w] = 1'b0;
    endtask

    function automatic int model_victim(int s);
        for (int w = 0; w < 8; w++) begin
            if (!mvalid8[s][w]) return w;
        end
        return order8[s][7];
    endfunction

    function automatic bit model_has_invalid(int s);
        for (int w = 0; w < 8; w++) begin
            if (!mvalid8[s][w]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- stimulus drivers ----------------
    task automatic op8(bit av, int as, int aw, bit iv, int is, int iw);
        a8_v = av; a8_s = 4'(as); a8_w = 3'(aw);
        i8_v = iv; i8_s = 4'(is); i8_w = 3'(iw);
        @(posedge clk);
        if (av) model_access(as, aw);
        if (iv && !(av && as == is)) model_inval(is, iw);
        #1;
        a8_v = 1'b0; i8_v = 1'b0;
    endtask

    task automatic op4(int as, int aw);
        a4_v = 1'b1; a4_s = 4'(as); a4_w = 2'(aw);
        @(posedge clk);
        #1;
        a4_v = 1'b0;
    endtask

    task automatic pulse_reset(bit with_access);
        rst = 1'b1;
        a8_v = with_access; a8_s = 4'd5; a8_w = 3'd3;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0; a8_v = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        pulse_reset(1'b0);
        for (int s = 0; s < 16; s++) begin
            q8_s = 4'(s); q4_s = 4'(s);
            #2;
            checks++;
            if (e8_w !== 3'd0 || e8_inv !== 1'b1 || f8 !== 1'b0)
                $display("FAIL reset8 set=%0d got way=%0d inv=%0b full=%0b want 0/1/0", s, e8_w, e8_inv, f8);
            else passed++;
            checks++;
            if (e4_w !== 2'd0 || e4_inv !== 1'b1 || f4 !== 1'b0)
                $display("FAIL reset4 set=%0d got way=%0d inv=%0b full=%0b want 0/1/0", s, e4_w, e4_inv, f4);
            else passed++;
        end
    endtask

    task automatic test_fill4();
        int seq1 [4] = '{2, 0, 3, 1};
        int seq2 [3] = '{3, 1, 2};
        q4_s = 4'd0;
        foreach (seq1[i]) op4(0, seq1[i]);
        #2;
        checks++;
        if (e4_w !== 2'd2 || e4_inv !== 1'b0 || f4 !== 1'b1)
            $display("FAIL fill4 got way=%0d inv=%0b full=%0b want 2/0/1", e4_w, e4_inv, f4);
        else passed++;
        foreach (seq2[i]) op4(0, seq2[i]);
        #2;
        checks++;
        if (e4_w !== 2'd0 || e4_inv !== 1'b0)
            $display("FAIL reorder4 got way=%0d inv=%0b want 0/0", e4_w, e4_inv);
        else passed++;
        op4(0, 2);
        #2;
        checks++;
        if (e4_w !== 2'd0 || f4 !== 1'b1)
            $display("FAIL mru_reaccess4 got way=%0d full=%0b want 0/1", e4_w, f4);
        else passed++;
    endtask

    task automatic test_fill8();
        int seq [8] = '{0, 3, 5, 7, 4, 2, 6, 1};
        q8_s = 4'd5;
        for (int r = 0; r < 2; r++) foreach (seq[i]) op8(1, 5, seq[i], 0, 0, 0);
        #2;
        checks++;
        if (e8_w !== 3'd0 || e8_inv !== 1'b0 || f8 !== 1'b1)
            $display("FAIL fill8 got way=%0d inv=%0b full=%0b want 0/0/1", e8_w, e8_inv, f8);
        else passed++;
        op8(0, 0, 0, 1, 5, 5);
        #2;
        checks++;
        if (e8_w !== 3'd5 || e8_inv !== 1'b1 || f8 !== 1'b0)
            $display("FAIL inval8 got way=%0d inv=%0b full=%0b want 5/1/0", e8_w, e8_inv, f8);
        else passed++;
        op8(1, 5, 5, 0, 0, 0);
        #2;
        checks++;
        if (e8_w !== 3'd0 || e8_inv !== 1'b0 || f8 !== 1'b1)
            $display("FAIL refill8 got way=%0d inv=%0b full=%0b want 0/0/1", e8_w, e8_inv, f8);
        else passed++;
    endtask

    task automatic test_isolation();
        for (int i = 0; i < 3; i++) op8(1, 2, 0, 0, 0, 0);
        q8_s = 4'd5;
        #2;
        checks++;
        if (e8_w !== 3'd0 || f8 !== 1'b1)
            $display("FAIL isolation_set5 got way=%0d full=%0b want 0/1", e8_w, f8);
        else passed++;
        q8_s = 4'd2;
        #2;
        checks++;
        if (e8_w !== 3'd1 || e8_inv !== 1'b1 || f8 !== 1'b0)
            $display("FAIL isolation_set2 got way=%0d inv=%0b full=%0b want 1/1/0", e8_w, e8_inv, f8);
        else passed++;
    endtask

    task automatic test_same_cycle();
        for (int w = 0; w < 8; w++) op8(1, 1, w, 0, 0, 0);
        for (int w = 0; w < 8; w++) op8(1, 4, w, 0, 0, 0);
        // Same set: the access lands and the invalidate is dropped.
        op8(1, 1, 3, 1, 1, 0);
        q8_s = 4'd1;
        #2;
        checks++;
        if (f8 !== 1'b1 || e8_w !== 3'd0 || e8_inv !== 1'b0)
            $display("FAIL same_set_drop got way=%0d inv=%0b full=%0b want 0/0/1", e8_w, e8_inv, f8);
        else passed++;
        checks++;
        if (dut8.age_reg[1][3] !== 3'd0)
            $display("FAIL same_set_mru got age=%0d want 0", dut8.age_reg[1][3]);
        else passed++;
        // Different sets: both updates land.
        op8(1, 1, 2, 1, 4, 2);
        q8_s = 4'd4;
        #2;
        checks++;
        if (e8_w !== 3'd2 || e8_inv !== 1'b1 || f8 !== 1'b0)
            $display("FAIL diff_set_inval got way=%0d inv=%0b full=%0b want 2/1/0", e8_w, e8_inv, f8);
        else passed++;
        checks++;
        if (dut8.age_reg[1][2] !== 3'd0 || dut8.age_reg[4][2] !== 3'd7)
            $display("FAIL diff_set_ages got set1w2=%0d set4w2=%0d want 0/7", dut8.age_reg[1][2], dut8.age_reg[4][2]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        pulse_reset(1'b1);
        for (int s = 0; s < 16; s++) begin
            q8_s = 4'(s);
            #2;
            checks++;
            if (e8_w !== 3'd0 || e8_inv !== 1'b1 || f8 !== 1'b0)
                $display("FAIL reset_mid set=%0d got way=%0d inv=%0b full=%0b want 0/1/0", s, e8_w, e8_inv, f8);
            else passed++;
        end
        checks++;
        if (dut8.valid_reg[5] !== 8'h00 || dut8.age_reg[5][3] !== 3'd3)
            $display("FAIL reset_mid_access got valid=%h age3=%0d want 00/3", dut8.valid_reg[5], dut8.age_reg[5][3]);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bit av, iv;
            int as, is, qs;
            logic [7:0][2:0] exp_age;
            logic [7:0]      exp_valid;
            av = ($urandom_range(0, 3) != 0);
            iv = ($urandom_range(0, 2) == 0);
            as = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            is = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            qs = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            q8_s = 4'(qs);
            a8_v = av; a8_s = 4'(as); a8_w = 3'($urandom_range(0, 7));
            i8_v = iv; i8_s = 4'(is); i8_w = 3'($urandom_range(0, 7));
            #2;
            // The query sees the state before this cycle's updates.
            checks++;
            if (e8_w !== 3'(model_victim(qs)) || e8_inv !== model_has_invalid(qs) || f8 !== !model_has_invalid(qs))
                $display("FAIL rand_victim n=%0d set=%0d got way=%0d inv=%0b full=%0b want %0d/%0b/%0b",
                         n, qs, e8_w, e8_inv, f8, model_victim(qs), model_has_invalid(qs), !model_has_invalid(qs));
            else passed++;
            @(posedge clk);
            if (av) model_access(as, int'(a8_w));
            if (iv && !(av && as == is)) model_inval(is, int'(i8_w));
            #1;
            a8_v = 1'b0; i8_v = 1'b0;
            for (int s = 0; s < 16; s++) begin
                for (int w = 0; w < 8; w++) begin
                    exp_age[w]   = 3'(model_pos(s, w));
                    exp_valid[w] = mvalid8[s][w];
                end
                checks++;
                if (dut8.age_reg[s] !== exp_age || dut8.valid_reg[s] !== exp_valid)
                    $display("FAIL rand_state n=%0d set=%0d got ages=%h valid=%h want ages=%h valid=%h",
                             n, s, dut8.age_reg[s], dut8.valid_reg[s], exp_age, exp_valid);
                else passed++;
            end
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_fill4();
        test_fill8();
        test_isolation();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
